branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised EX-stage branch resolver that replaces the plain combinational branch comparator.
- Evaluates all six RV32 conditional branches plus JAL/JALR and computes the target.
- Compares the actual outcome against the front-end prediction and issues a registered redirect/flush.
- Maintains a 2-bit bimodal branch history table (BHT) that the IF stage queries, plus saturating branch/mispredict statistics counters.

Parameters:
XLEN, 32, datapath width of operands, PC and immediate
BHT_IDX_BITS, 6, log2 of BHT entry count (64 entries)
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
if_pc  in  XLEN  IF-stage PC for prediction lookup
if_pred_taken  out  1  combinational BHT prediction: counter[if_pc index][1]
ex_valid  in  1  EX-stage control-flow instruction present
ex_is_branch  in  1  conditional branch
ex_is_jal  in  1  JAL
ex_is_jalr  in  1  JALR
ex_funct3  in  3  branch condition
ex_rs1  in  XLEN  first operand (forwarded)
ex_rs2  in  XLEN  second operand (forwarded)
ex_pc  in  XLEN  instruction PC
ex_imm  in  XLEN  sign-extended immediate
ex_pred_taken  in  1  prediction carried from IF
redirect_valid  out  1  registered: flush younger instructions and load redirect_pc
redirect_pc  out  XLEN  registered correct next PC
resolved_taken  out  1  registered actual outcome of the last accepted instruction
illegal_branch  out  1  registered: funct3 was 010 or 011
branch_count  out  CNT_W  accepted conditional branches
mispredict_count  out  CNT_W  accepted instructions that caused a redirect

Behaviour:
- Reset (synchronous): all registered outputs 0; both counters 0; every BHT entry 2'b01 (weakly not-taken). Reset mid-operation drops any pending redirect.
- Index: idx = pc[BHT_IDX_BITS+1:2] for both if_pc and ex_pc.
- Accept:
  - accept = ex_valid & ~redirect_valid & exactly one of is_branch/is_jal/is_jalr set.
  - In the cycle redirect_valid is high, the EX slot holds a wrong-path instruction. It is ignored: no BHT update, no counting, no new redirect.
  - Multiple type flags set means no accept.
- Condition (is_branch):
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010/011: taken=0, illegal_branch=1 next cycle, no BHT update, branch_count still increments.
- Target, all mod 2^XLEN:
  - branch/JAL: ex_pc+ex_imm.
  - JALR: (ex_rs1+ex_imm) with bit0 cleared.
  - fallthrough: ex_pc+4.
  - JAL/JALR always taken.
- Mispredict:
  - branch: taken != ex_pred_taken.
  - JAL: ex_pred_taken==0.
  - JALR: always (no target prediction).
- Latency: outputs registered one cycle after accept.
  - redirect_valid=mispredict.
  - redirect_pc = taken ? target : ex_pc+4.
  - resolved_taken=taken.
  - Non-accept cycles: redirect_valid=0, illegal_branch=0. redirect_pc and resolved_taken hold their values.
- Redirect pulse is exactly one cycle; it never asserts on consecutive cycles.
- BHT update, at the same edge as the output registers, for accepted legal conditional branches only:
  - taken: counter+1, saturating at 3.
  - not taken: counter-1, saturating at 0.
- Same-cycle read and write of the same index: if_pred_taken returns the pre-update value.
- Counters:
  - branch_count +1 per accepted is_branch.
  - mispredict_count +1 per accepted mispredict.
  - Both saturate at all-ones; no wrap.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0. All outputs are 0 the cycle after reset deasserts.
- BEQ rs1=rs2=5, pc=0x40, imm=0x20, pred=0 -> next cycle redirect_valid=1, redirect_pc=0x60, mispredict_count=1. Entry 16 becomes 2'b10, so if_pc=0x40 now predicts 1.
- BLT rs1=0xFFFFFFFF, rs2=1, pred=1 -> no redirect, resolved_taken=1. The same operands with BLTU, pred=1 -> redirect to pc+4.
- JALR rs1=0x1003, imm=4 -> redirect_pc=0x1006 even with pred=1. The valid branch the following cycle is ignored: counts and BHT unchanged, redirect_valid low.
- Four taken BNEs at the same PC -> counter saturates at 3. Five not-taken -> saturates at 0. Each direction flip costs the expected mispredicts.
- funct3=010 accepted -> illegal_branch=1 for one cycle, BHT unchanged. Assert reset while redirect_valid is pending -> redirect_valid=0 next cycle and counters are 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch/jump resolver. It evaluates RV32
// conditional branches, JAL and JALR, checks the outcome against the
// front-end prediction and issues a registered one-cycle redirect. It also
// keeps a 2-bit bimodal BHT for IF-stage lookup and saturating statistics.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int BHT_IDX_BITS = 6,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             resolved_taken,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int BHT_N = 1 << BHT_IDX_BITS;

  // BHT storage: 2-bit counters, MSB is the prediction
  logic [1:0] bht_q [BHT_N];

  logic [BHT_IDX_BITS-1:0] if_idx, ex_idx;
  logic                    if_pc_unused;

  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             resolved_taken_q, resolved_taken_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic [2:0]      type_sel;
  logic            one_hot, accept;
  logic            illegal_f3, br_cond, taken, mispredict;
  logic [XLEN-1:0] br_target, jalr_sum, target, fallthrough, next_pc;
  logic            bht_we;
  logic [1:0]      bht_cur, bht_nxt;

  // Word-aligned PC bits index the table; the rest of if_pc is not needed
  assign if_idx        = if_pc[BHT_IDX_BITS+1:2];
  assign ex_idx        = ex_pc[BHT_IDX_BITS+1:2];
  assign if_pc_unused  = ^{if_pc[XLEN-1:BHT_IDX_BITS+2], if_pc[1:0]};
  assign if_pred_taken = bht_q[if_idx][1];

  // Resolve condition, target and mispredict for the EX-slot instruction
  always_comb begin
    type_sel   = {ex_is_branch, ex_is_jal, ex_is_jalr};
    one_hot    = (type_sel == 3'b100) || (type_sel == 3'b010) || (type_sel == 3'b001);
    // The EX slot is wrong-path while a redirect is on the wire
    accept     = ex_valid & ~redirect_valid_q & one_hot;
    illegal_f3 = ex_is_branch & (ex_funct3[2:1] == 2'b01);

    br_cond = 1'b0;
    case (ex_funct3)
      3'b000:  br_cond = (ex_rs1 == ex_rs2);
      3'b001:  br_cond = (ex_rs1 != ex_rs2);
      3'b100:  br_cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  br_cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  br_cond = (ex_rs1 <  ex_rs2);
      3'b111:  br_cond = (ex_rs1 >= ex_rs2);
      default: br_cond = 1'b0;
    endcase

    // Jumps are unconditionally taken
    taken       = ex_is_branch ? br_cond : 1'b1;
    br_target   = ex_pc + ex_imm;
    jalr_sum    = ex_rs1 + ex_imm;
    fallthrough = ex_pc + XLEN'(4);
    target      = ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_target;
    next_pc     = taken ? target : fallthrough;

    // JALR has no target prediction, so it always redirects
    if (ex_is_branch)   mispredict = (taken != ex_pred_taken);
    else if (ex_is_jal) mispredict = ~ex_pred_taken;
    else                mispredict = 1'b1;
  end

  // Next-state for output registers and statistics counters
  always_comb begin
    redirect_valid_d = accept & mispredict;
    illegal_d        = accept & illegal_f3;
    redirect_pc_d    = accept ? next_pc : redirect_pc_q;
    resolved_taken_d = accept ? taken : resolved_taken_q;
    br_cnt_d         = br_cnt_q;
    mis_cnt_d        = mis_cnt_q;
    if (accept && ex_is_branch && (br_cnt_q != '1))
      br_cnt_d = br_cnt_q + CNT_W'(1);
    if (accept && mispredict && (mis_cnt_q != '1))
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
  end

  // BHT counter update: only legal, accepted conditional branches train it
  always_comb begin
    bht_we  = accept & ex_is_branch & ~illegal_f3;
    bht_cur = bht_q[ex_idx];
    bht_nxt = bht_cur;
    if (taken) begin
      if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'b01;
    end
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      resolved_taken_q <= 1'b0;
      illegal_q        <= 1'b0;
      br_cnt_q         <= '0;
      mis_cnt_q        <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      resolved_taken_q <= resolved_taken_d;
      illegal_q        <= illegal_d;
      br_cnt_q         <= br_cnt_d;
      mis_cnt_q        <= mis_cnt_d;
    end
  end

  // BHT array: reset to weakly not-taken; IF reads see the pre-update value
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[ex_idx] <= bht_nxt;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign resolved_taken   = resolved_taken_q;
  assign illegal_branch   = illegal_q;
  assign branch_count     = br_cnt_q;
  assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: inputs change 1ns after the
// rising edge, outputs are checked 1ns after the following rising edge.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm;
  logic        ex_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        resolved_taken, illegal_branch;
  logic [31:0] branch_count, mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .resolved_taken(resolved_taken), .illegal_branch(illegal_branch),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_pc = 0; ex_imm = 0; ex_pred_taken = 0;
  endtask

  task automatic drive_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    drive_idle();
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = f3;
    ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm; ex_pred_taken = pred;
  endtask

  task automatic drive_jump(input logic is_jalr, input logic [31:0] a, input logic [31:0] pc,
                            input logic [31:0] imm, input logic pred);
    drive_idle();
    ex_valid = 1; ex_is_jal = ~is_jalr; ex_is_jalr = is_jalr;
    ex_rs1 = a; ex_pc = pc; ex_imm = imm; ex_pred_taken = pred;
  endtask

  task automatic test_reset();
    drive_idle(); if_pc = 32'h100; reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred got=%0b exp=0", if_pred_taken); end
    tick();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got=%0b exp=0", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
    n_checks++; if (resolved_taken !== 1'b0) begin n_fail++; $display("FAIL reset_rt got=%0b exp=0", resolved_taken); end
    n_checks++; if (illegal_branch !== 1'b0) begin n_fail++; $display("FAIL reset_ill got=%0b exp=0", illegal_branch); end
    n_checks++; if (branch_count !== 32'd0) begin n_fail++; $display("FAIL reset_bc got=%0d exp=0", branch_count); end
    n_checks++; if (mispredict_count !== 32'd0) begin n_fail++; $display("FAIL reset_mc got=%0d exp=0", mispredict_count); end
  endtask

  task automatic test_beq();
    drive_br(3'b000, 32'd5, 32'd5, 32'h40, 32'h20, 1'b0);
    tick();
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_rv got=%0b exp=1", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h60) begin n_fail++; $display("FAIL beq_rpc got=%h exp=60", redirect_pc); end
    n_checks++; if (mispredict_count !== 32'd1) begin n_fail++; $display("FAIL beq_mc got=%0d exp=1", mispredict_count); end
    n_checks++; if (branch_count !== 32'd1) begin n_fail++; $display("FAIL beq_bc got=%0d exp=1", branch_count); end
    drive_idle(); if_pc = 32'h40; #1;
    n_checks++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL beq_bht got=%0b exp=1", if_pred_taken); end
    tick();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL beq_pulse got=%0b exp=0", redirect_valid); end
  endtask

  task automatic test_blt_bltu();
    drive_br(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h80, 32'h10, 1'b1);
    tick();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL blt_rv got=%0b exp=0", redirect_valid); end
    n_checks++; if (resolved_taken !== 1'b1) begin n_fail++; $display("FAIL blt_rt got=%0b exp=1", resolved_taken); end
    n_checks++; if (redirect_pc !== 32'h90) begin n_fail++; $display("FAIL blt_rpc got=%h exp=90", redirect_pc); end
    drive_br(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h80, 32'h10, 1'b1);
    tick();
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL bltu_rv got=%0b exp=1", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h84) begin n_fail++; $display("FAIL bltu_rpc got=%h exp=84", redirect_pc); end
    n_checks++; if (resolved_taken !== 1'b0) begin n_fail++; $display("FAIL bltu_rt got=%0b exp=0", resolved_taken); end
    n_checks++; if (branch_count !== 32'd3 || mispredict_count !== 32'd2) begin n_fail++;
      $display("FAIL bltu_cnt got=%0d/%0d exp=3/2", branch_count, mispredict_count); end
    drive_idle(); tick();
  endtask

  task automatic test_jalr_shadow();
    drive_jump(1'b1, 32'h1003, 32'h200, 32'd4, 1'b1);
    tick();
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL jalr_rv got=%0b exp=1", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h1006) begin n_fail++; $display("FAIL jalr_rpc got=%h exp=1006", redirect_pc); end
    n_checks++; if (mispredict_count !== 32'd3) begin n_fail++; $display("FAIL jalr_mc got=%0d exp=3", mispredict_count); end
    // wrong-path branch in the redirect cycle must be ignored
    drive_br(3'b000, 32'd9, 32'd9, 32'h300, 32'h8, 1'b0);
    tick();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL shadow_rv got=%0b exp=0", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h1006) begin n_fail++; $display("FAIL shadow_rpc got=%h exp=1006", redirect_pc); end
    n_checks++; if (branch_count !== 32'd3 || mispredict_count !== 32'd3) begin n_fail++;
      $display("FAIL shadow_cnt got=%0d/%0d exp=3/3", branch_count, mispredict_count); end
    drive_idle(); if_pc = 32'h300; #1;
    n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL shadow_bht got=%0b exp=0", if_pred_taken); end
    tick();
  endtask

  task automatic test_jal();
    drive_jump(1'b0, 32'h0, 32'h500, 32'h100, 1'b1);
    tick();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jal_hit_rv got=%0b exp=0", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h600 || resolved_taken !== 1'b1) begin n_fail++;
      $display("FAIL jal_hit_rpc got=%h/%0b exp=600/1", redirect_pc, resolved_taken); end
    drive_jump(1'b0, 32'h0, 32'h500, 32'hFFFF_FFF8, 1'b0);
    tick();
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4F8) begin n_fail++;
      $display("FAIL jal_miss got=%0b/%h exp=1/4f8", redirect_valid, redirect_pc); end
    n_checks++; if (mispredict_count !== 32'd4 || branch_count !== 32'd3) begin n_fail++;
      $display("FAIL jal_cnt got=%0d/%0d exp=4/3", mispredict_count, branch_count); end
    drive_idle(); tick();
  endtask

  task automatic test_conditions();
    logic [2:0]  f3 [9] = '{3'b000, 3'b000, 3'b001, 3'b101, 3'b101, 3'b101, 3'b111, 3'b110, 3'b100};
    logic [31:0] ra [9] = '{32'd7, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'd5, 32'hFFFF_FFFE, 32'd1, 32'd5};
    logic [31:0] rb [9] = '{32'd7, 32'd8, 32'd8, 32'd1, 32'hFFFF_FFFE, 32'd5, 32'd1, 32'hFFFF_FFFE, 32'd5};
    logic        ex [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive_br(f3[i], ra[i], rb[i], 32'h400, 32'h10, ex[i]);
      tick();
      n_checks++; if (resolved_taken !== ex[i] || redirect_valid !== 1'b0) begin n_fail++;
        $display("FAIL cond_%0d got=%0b/%0b exp=%0b/0", i, resolved_taken, redirect_valid, ex[i]); end
      n_checks++; if (redirect_pc !== (ex[i] ? 32'h410 : 32'h404)) begin n_fail++;
        $display("FAIL cond_pc_%0d got=%h", i, redirect_pc); end
    end
    drive_idle(); tick();
    n_checks++; if (branch_count !== 32'd12) begin n_fail++; $display("FAIL cond_bc got=%0d exp=12", branch_count); end
  endtask

  task automatic test_saturate();
    logic tk [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic pi [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic rd [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic pa [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if_pc = 32'h24;
    for (int i = 0; i < 10; i++) begin
      drive_br(3'b001, 32'd1, tk[i] ? 32'd2 : 32'd1, 32'h24, 32'h40, pi[i]);
      #1;
      n_checks++; if (if_pred_taken !== pi[i]) begin n_fail++;
        $display("FAIL sat_pre_%0d got=%0b exp=%0b", i, if_pred_taken, pi[i]); end
      tick();
      n_checks++; if (redirect_valid !== rd[i]) begin n_fail++;
        $display("FAIL sat_rv_%0d got=%0b exp=%0b", i, redirect_valid, rd[i]); end
      n_checks++; if (redirect_pc !== (tk[i] ? 32'h64 : 32'h28)) begin n_fail++;
        $display("FAIL sat_rpc_%0d got=%h", i, redirect_pc); end
      n_checks++; if (if_pred_taken !== pa[i]) begin n_fail++;
        $display("FAIL sat_post_%0d got=%0b exp=%0b", i, if_pred_taken, pa[i]); end
      drive_idle(); tick();
    end
    n_checks++; if (branch_count !== 32'd22 || mispredict_count !== 32'd8) begin n_fail++;
      $display("FAIL sat_cnt got=%0d/%0d exp=22/8", branch_count, mispredict_count); end
  endtask

  task automatic test_multi_flag();
    drive_br(3'b000, 32'd1, 32'd1, 32'h40, 32'h20, 1'b0);
    ex_is_jal = 1;
    tick();
    n_checks++; if (redirect_valid !== 1'b0 || branch_count !== 32'd22 || mispredict_count !== 32'd8) begin n_fail++;
      $display("FAIL multi got=%0b/%0d/%0d exp=0/22/8", redirect_valid, branch_count, mispredict_count); end
    drive_idle(); tick();
  endtask

  task automatic test_illegal_and_reset();
    if_pc = 32'h40;
    drive_br(3'b010, 32'd3, 32'd3, 32'h40, 32'h20, 1'b0);
    tick();
    n_checks++; if (illegal_branch !== 1'b1 || redirect_valid !== 1'b0) begin n_fail++;
      $display("FAIL ill_010 got=%0b/%0b exp=1/0", illegal_branch, redirect_valid); end
    n_checks++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL ill_bht got=%0b exp=1", if_pred_taken); end
    n_checks++; if (branch_count !== 32'd23) begin n_fail++; $display("FAIL ill_bc got=%0d exp=23", branch_count); end
    drive_idle(); tick();
    n_checks++; if (illegal_branch !== 1'b0) begin n_fail++; $display("FAIL ill_pulse got=%0b exp=0", illegal_branch); end
    drive_br(3'b011, 32'd3, 32'd3, 32'h40, 32'h20, 1'b1);
    tick();
    n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h44 || illegal_branch !== 1'b1) begin n_fail++;
      $display("FAIL ill_011 got=%0b/%h/%0b exp=1/44/1", redirect_valid, redirect_pc, illegal_branch); end
    n_checks++; if (mispredict_count !== 32'd9) begin n_fail++; $display("FAIL ill_mc got=%0d exp=9", mispredict_count); end
    drive_idle(); reset = 1;
    tick();
    n_checks++; if (redirect_valid !== 1'b0 || branch_count !== 32'd0 || mispredict_count !== 32'd0) begin n_fail++;
      $display("FAIL mid_reset got=%0b/%0d/%0d exp=0/0/0", redirect_valid, branch_count, mispredict_count); end
    n_checks++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL mid_reset_bht got=%0b exp=0", if_pred_taken); end
    reset = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_beq();
    test_blt_bltu();
    test_jalr_shadow();
    test_jal();
    test_conditions();
    test_saturate();
    test_multi_flag();
    test_illegal_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
